// File: rtl/ysyx_22050550_lsu_pkg.sv
// Shared types and constants for the load/store stage: FSM encoding, sideband layout,
// func3 encodings and helpers for access size decoding.
package ysyx_22050550_lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } lsu_state_e;

   // Sideband packing, LSB first; fields fill exactly 256 bits.
   localparam int SIDE_PC_LSB    = 0;
   localparam int SIDE_PC_W      = 64;
   localparam int SIDE_INST_LSB  = 64;
   localparam int SIDE_INST_W    = 32;
   localparam int SIDE_RS1_LSB   = 96;
   localparam int SIDE_RS1_W     = 5;
   localparam int SIDE_FLAGS_LSB = 101;
   localparam int SIDE_FLAGS_W   = 9;
   localparam int SIDE_IMM_LSB   = 110;
   localparam int SIDE_IMM_W     = 64;
   localparam int SIDE_RS2_LSB   = 174;
   localparam int SIDE_RS2_W     = 5;
   localparam int SIDE_WADDR_LSB = 179;
   localparam int SIDE_WADDR_W   = 5;
   localparam int SIDE_WEN_LSB   = 184;
   localparam int SIDE_WEN_W     = 1;
   localparam int SIDE_FUNC7_LSB = 185;
   localparam int SIDE_FUNC7_W   = 7;
   localparam int SIDE_NPC_LSB   = 192;
   localparam int SIDE_NPC_W     = 64;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   function automatic logic [7:0] mask_base(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      logic bad;
      case (size)
         2'b01:   bad = off[0];
         2'b10:   bad = |off[1:0];
         2'b11:   bad = |off;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ysyx_22050550_load_ext.sv
// Load data alignment: shifts the 8-byte memory word down to the accessed byte
// lane and sign/zero extends according to func3.
module ysyx_22050550_load_ext
   import ysyx_22050550_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      offset,
   input  logic [2:0]      func3,
   output logic [XLEN-1:0] lsures
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      lsures  = '0;
      case (func3)
         F3_LB:   lsures = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_LH:   lsures = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LW:   lsures = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_LD:   lsures = shifted;
         F3_LBU:  lsures = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_LHU:  lsures = {{(XLEN-16){1'b0}}, shifted[15:0]};
         F3_LWU:  lsures = {{(XLEN-32){1'b0}}, shifted[31:0]};
         default: lsures = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_22050550_lsu.sv
// Load/store stage: captures one EX bundle at a time, issues a single data-memory
// request for loads/stores, and hands the result bundle to the WBU.
module ysyx_22050550_lsu
   import ysyx_22050550_lsu_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int SIDE_W = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_EXLS_valid,
   output logic              io_EXLS_ready,
   input  logic [SIDE_W-1:0] io_EXLS_side,
   input  logic [XLEN-1:0]   io_EXLS_alures,
   input  logic [XLEN-1:0]   io_EXLS_rs2,
   input  logic [2:0]        io_EXLS_func3,
   input  logic              io_EXLS_readflag,
   input  logic              io_EXLS_writeflag,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic              mem_req_wen,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_resp_rdata,
   output logic              io_LSWB_valid,
   input  logic              io_LSWB_ready,
   output logic [SIDE_W-1:0] io_LSWB_side,
   output logic [XLEN-1:0]   io_LSWB_alures,
   output logic [XLEN-1:0]   io_LSWB_lsures,
   output logic              io_LSWB_readflag,
   output logic [2:0]        io_LSWB_func3,
   output logic              io_LSWB_abort
);

   lsu_state_e state_q, state_d;

   logic              cap_ex, cap_resp;
   logic              is_mem_in, misal_in;
   logic [SIDE_W-1:0] side_p1;
   logic [XLEN-1:0]   alures_p1, rs2_p1, lsures_p1, ext_data;
   logic [2:0]        func3_p1, offset_p1;
   logic              rd_p1, wr_p1, abort_p1;

   assign is_mem_in = io_EXLS_readflag | io_EXLS_writeflag;
   assign misal_in  = misaligned(io_EXLS_func3[1:0], io_EXLS_alures[2:0]);
   assign offset_p1 = alures_p1[2:0];

   always_comb begin
      state_d       = state_q;
      io_EXLS_ready = 1'b0;
      mem_req_valid = 1'b0;
      io_LSWB_valid = 1'b0;
      cap_ex        = 1'b0;
      cap_resp      = 1'b0;
      case (state_q)
         S_IDLE: begin
            io_EXLS_ready = 1'b1;
            if (io_EXLS_valid) begin
               cap_ex  = 1'b1;
               state_d = (!is_mem_in || misal_in) ? S_OUT : S_REQ;
            end
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               // A response in the acceptance cycle lets us skip WAIT entirely.
               if (mem_resp_valid) begin
                  cap_resp = 1'b1;
                  state_d  = S_OUT;
               end else begin
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               cap_resp = 1'b1;
               state_d  = S_OUT;
            end
         end
         S_OUT: begin
            io_LSWB_valid = 1'b1;
            if (io_LSWB_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Capture stage: EX bundle and, later, the extended memory response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         side_p1   <= '0;
         alures_p1 <= '0;
         rs2_p1    <= '0;
         func3_p1  <= '0;
         rd_p1     <= 1'b0;
         wr_p1     <= 1'b0;
         abort_p1  <= 1'b0;
         lsures_p1 <= '0;
      end else if (cap_ex) begin
         side_p1   <= io_EXLS_side;
         alures_p1 <= io_EXLS_alures;
         rs2_p1    <= io_EXLS_rs2;
         func3_p1  <= io_EXLS_func3;
         rd_p1     <= io_EXLS_readflag;
         wr_p1     <= io_EXLS_writeflag;
         abort_p1  <= is_mem_in & misal_in;
         lsures_p1 <= '0;
      end else if (cap_resp) begin
         lsures_p1 <= rd_p1 ? ext_data : '0;
      end
   end

   ysyx_22050550_load_ext #(.XLEN(XLEN)) u_load_ext (
      .rdata  (mem_resp_rdata),
      .offset (offset_p1),
      .func3  (func3_p1),
      .lsures (ext_data)
   );

   // Request fields are forced to zero outside REQ so the bus idles quietly.
   assign mem_req_addr  = mem_req_valid ? {alures_p1[XLEN-1:3], 3'b000} : '0;
   assign mem_req_wen   = mem_req_valid & wr_p1 & ~rd_p1;
   assign mem_req_wdata = mem_req_valid ? (rs2_p1 << {offset_p1, 3'b000}) : '0;
   assign mem_req_wmask = mem_req_valid ? (mask_base(func3_p1[1:0]) << offset_p1) : 8'h00;

   assign io_LSWB_side     = side_p1;
   assign io_LSWB_alures   = alures_p1;
   assign io_LSWB_lsures   = lsures_p1;
   assign io_LSWB_readflag = rd_p1;
   assign io_LSWB_func3    = func3_p1;
   assign io_LSWB_abort    = abort_p1;

endmodule
